// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the UART receiver and transmitter.
//   state_t       - receiver FSM states
//   DATA_BITS_DEF - default payload width per frame
//   clog2()       - ceiling log2, used to size counters at elaboration
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int DATA_BITS_DEF = 8;

    // Number of bits needed to count 0 .. v-1 (returns 0 for v <= 1).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// sync_2ff: single-bit two-flop synchronizer for an asynchronous input.
//   clk   - destination clock
//   rst   - asynchronous active-high reset, flops load RST_VAL
//   d     - asynchronous input
//   q     - synchronized output (two clk edges of latency)
`timescale 1ns/1ps
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling.
//   clk       - system clock, rising edge
//   rst       - asynchronous active-high reset
//   rx        - serial line, idle high, asynchronous to clk
//   data      - last correctly received byte, held until the next good frame
//   valid     - one-cycle pulse, data updated this cycle
//   frame_err - one-cycle pulse, stop bit sampled low, byte discarded
//   busy      - FSM is not in IDLE
`timescale 1ns/1ps
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2812,
    parameter int DATA_BITS    = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    if (CLKS_PER_BIT < 4) begin : g_bad_cpb
        $error("uart_rx: CLKS_PER_BIT must be >= 4");
    end

    localparam int CW = clog2(CLKS_PER_BIT);
    localparam int BW = clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    // Input path: synchronizer plus one history flop for edge detection.
    logic rx_s;
    logic rx_prev;
    logic fall;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_prev <= 1'b1;
        else     rx_prev <= rx_s;
    end

    // Requiring an edge (not just a low level) keeps a break or a line
    // still low after a framing error from re-triggering.
    assign fall = rx_prev & ~rx_s;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end

            // Wait to the middle of the start bit; a high line there means
            // the edge was a glitch.
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            // From mid-start, every full bit period lands mid-bit. LSB arrives
            // first, so shift in at the top and it ends up at bit 0.
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d                = '0;
                    sh_d                 = sh_q >> 1;
                    sh_d[DATA_BITS-1]    = rx_s;
                    if (bit_q == LAST_BIT) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            // Leaving at mid-stop leaves half a bit to catch the next start
            // edge of a back-to-back frame.
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx_s) begin
                        data_d  = sh_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at CLKS_PER_BIT=16.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int vectors = 0;
    int miss    = 0;
    int cyc     = 0;
    int vcnt    = 0;
    int fcnt    = 0;
    int both    = 0;
    int         vtime[$];
    logic [7:0] vdata[$];
    logic       vbusy[$];

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (valid) begin
            vcnt++;
            vtime.push_back(cyc);
            vdata.push_back(data);
            vbusy.push_back(busy);
        end
        if (frame_err) fcnt++;
        if (valid && frame_err) both++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        vectors++;
        assert (obs >= lo && obs <= hi) else begin
            miss++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Called at a negedge; drives one frame at exact bit periods.
    task automatic send(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
    endtask

    int t0;
    int v0;
    int f0;
    int bad;
    int bcnt;

    initial begin
        // 1. reset, run, reset again mid-run, then 200 quiet cycles
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_data",  {24'd0, data}, 32'h00);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_ferr",  {31'd0, frame_err}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (data !== 8'h00 || valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("rst_quiet200", bad, 0);

        // 2. single frame 0x55
        v0 = vcnt;
        t0 = cyc;
        send(8'h55, 1'b1);
        chk("f55_count", vcnt - v0, 1);
        if (vcnt > v0) begin
            chk_rng("f55_latency", vtime[v0] - t0, 153, 157);
            chk("f55_data", {24'd0, vdata[v0]}, 32'h55);
            chk("f55_busy_at_valid", {31'd0, vbusy[v0]}, 32'd0);
        end

        // 3. back-to-back 0xA3, 0x00, 0xFF
        repeat (10) @(negedge clk);
        v0 = vcnt;
        send(8'hA3, 1'b1);
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        repeat (4) @(negedge clk);
        chk("b2b_count", vcnt - v0, 3);
        if (vcnt >= v0 + 3) begin
            chk("b2b_d0", {24'd0, vdata[v0]},     32'hA3);
            chk("b2b_d1", {24'd0, vdata[v0 + 1]}, 32'h00);
            chk("b2b_d2", {24'd0, vdata[v0 + 2]}, 32'hFF);
            chk("b2b_gap01", vtime[v0 + 1] - vtime[v0], 160);
            chk("b2b_gap12", vtime[v0 + 2] - vtime[v0 + 1], 160);
        end

        // 4. 4-cycle glitch
        repeat (20) @(negedge clk);
        v0 = vcnt;
        f0 = fcnt;
        bcnt = 0;
        rx = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (busy) bcnt++;
        end
        rx = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (busy) bcnt++;
        end
        chk("glitch_busy_cycles", bcnt, 8);
        chk("glitch_busy_end", {31'd0, busy}, 32'd0);
        chk("glitch_no_valid", vcnt - v0, 0);
        chk("glitch_no_ferr", fcnt - f0, 0);

        // 5. framing error, held-low line, then recovery
        v0 = vcnt;
        f0 = fcnt;
        send(8'h3C, 1'b0);
        chk("ferr_count", fcnt - f0, 1);
        chk("ferr_no_valid", vcnt - v0, 0);
        chk("ferr_data_kept", {24'd0, data}, 32'hFF);
        repeat (500) @(negedge clk);
        chk("break_no_ferr", fcnt - f0, 1);
        chk("break_no_valid", vcnt - v0, 0);
        chk("break_busy", {31'd0, busy}, 32'd0);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        send(8'h81, 1'b1);
        chk("recover_count", vcnt - v0, 1);
        chk("recover_data", {24'd0, data}, 32'h81);

        // 6. reset during data bit 4 of 0x96, then 0x69
        repeat (10) @(negedge clk);
        v0 = vcnt;
        f0 = fcnt;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = (8'h96 >> i) & 8'h01;
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;  // bit 4 of 0x96
        repeat (CPB / 2) @(negedge clk);
        chk("midrst_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_busy_async", {31'd0, busy}, 32'd0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("midrst_no_valid", vcnt - v0, 0);
        chk("midrst_no_ferr", fcnt - f0, 0);
        chk("midrst_idle", {31'd0, busy}, 32'd0);
        send(8'h69, 1'b1);
        chk("after_rst_count", vcnt - v0, 1);
        chk("after_rst_data", {24'd0, data}, 32'h69);

        repeat (10) @(negedge clk);
        chk("exclusive", both, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end

endmodule
